rtc_config_writer: RTL and testbench

//  Consumes the BCD values edited by the configuration counters and writes them into the RTC

---
 rtl/rtc_cfg_pkg.sv | 86 ++++++++
 rtl/rtc_cfg_seq_table.sv | 56 +++++
 rtl/rtc_config_writer.sv | 195 +++++++++++++++++++
 tb/tb_rtc_config_writer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_cfg_pkg.sv
// Shared types and constants for the RTC configuration writer: mode codes,
// RTC register map, FSM encoding, per-group sequence lengths and snapshot payload.
package rtc_cfg_pkg;

    localparam int unsigned MODE_W = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = 8;

    localparam logic [MODE_W-1:0] MODE_NORMAL = 3'd0;
    localparam logic [MODE_W-1:0] MODE_TIME   = 3'd1;
    localparam logic [MODE_W-1:0] MODE_DATE   = 3'd2;
    localparam logic [MODE_W-1:0] MODE_TIMER  = 3'd4;

    localparam logic [ADDR_W-1:0] ADDR_SS   = 8'h21;
    localparam logic [ADDR_W-1:0] ADDR_MM   = 8'h22;
    localparam logic [ADDR_W-1:0] ADDR_HH   = 8'h23;
    localparam logic [ADDR_W-1:0] ADDR_DAY  = 8'h24;
    localparam logic [ADDR_W-1:0] ADDR_MES  = 8'h25;
    localparam logic [ADDR_W-1:0] ADDR_YEAR = 8'h26;
    localparam logic [ADDR_W-1:0] ADDR_WDAY = 8'h27;
    localparam logic [ADDR_W-1:0] ADDR_SS_T = 8'h41;
    localparam logic [ADDR_W-1:0] ADDR_MM_T = 8'h42;
    localparam logic [ADDR_W-1:0] ADDR_HH_T = 8'h43;

    // Number of writes per group, transfer command included
    localparam int unsigned LEN_TIME  = 4;
    localparam int unsigned LEN_DATE  = 5;
    localparam int unsigned LEN_TIMER = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_GAP    = 3'd2,
        ST_FINISH = 3'd3,
        ST_ABORT  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        GRP_TIME  = 2'd0,
        GRP_DATE  = 2'd1,
        GRP_TIMER = 2'd2
    } group_e;

    typedef enum logic [3:0] {
        SEL_SS   = 4'd0,
        SEL_MM   = 4'd1,
        SEL_HH   = 4'd2,
        SEL_DAY  = 4'd3,
        SEL_MES  = 4'd4,
        SEL_YEAR = 4'd5,
        SEL_WDAY = 4'd6,
        SEL_SS_T = 4'd7,
        SEL_MM_T = 4'd8,
        SEL_HH_T = 4'd9,
        SEL_CMD  = 4'd10
    } dsel_e;

    typedef struct packed {
        logic [DATA_W-1:0] ss;
        logic [DATA_W-1:0] mm;
        logic [DATA_W-1:0] hh;
        logic [DATA_W-1:0] year;
        logic [DATA_W-1:0] mes;
        logic [DATA_W-1:0] day;
        logic [DATA_W-1:0] wday;
        logic [DATA_W-1:0] ss_t;
        logic [DATA_W-1:0] mm_t;
        logic [DATA_W-1:0] hh_t;
        logic              am_pm;
    } snap_t;

    function automatic logic is_group_mode(input logic [MODE_W-1:0] m);
        return (m == MODE_TIME) || (m == MODE_DATE) || (m == MODE_TIMER);
    endfunction

    function automatic group_e mode_to_group(input logic [MODE_W-1:0] m);
        group_e g;
        g = GRP_TIMER;
        if (m == MODE_TIME) g = GRP_TIME;
        if (m == MODE_DATE) g = GRP_DATE;
        return g;
    endfunction

endpackage

// File: rtl/rtc_cfg_seq_table.sv
// Combinational write-sequence table: (group, index) -> RTC address, data source, last flag.
module rtc_cfg_seq_table
    import rtc_cfg_pkg::*;
#(
    parameter logic [ADDR_W-1:0] CMD_ADDR_TIME  = 8'hF1,
    parameter logic [ADDR_W-1:0] CMD_ADDR_TIMER = 8'hF2
) (
    input  group_e             group_i,
    input  logic [IDX_W-1:0]   idx_i,
    output logic [ADDR_W-1:0]  addr_c_o,
    output dsel_e              dsel_c_o,
    output logic               last_c_o
);

    always_comb begin
        addr_c_o = '0;
        dsel_c_o = SEL_CMD;
        last_c_o = 1'b0;
        case (group_i)
            GRP_TIME: begin
                last_c_o = (idx_i == IDX_W'(LEN_TIME - 1));
                case (idx_i)
                    3'd0:    begin addr_c_o = ADDR_SS;       dsel_c_o = SEL_SS;  end
                    3'd1:    begin addr_c_o = ADDR_MM;       dsel_c_o = SEL_MM;  end
                    3'd2:    begin addr_c_o = ADDR_HH;       dsel_c_o = SEL_HH;  end
                    default: begin addr_c_o = CMD_ADDR_TIME; dsel_c_o = SEL_CMD; end
                endcase
            end
            GRP_DATE: begin
                last_c_o = (idx_i == IDX_W'(LEN_DATE - 1));
                case (idx_i)
                    3'd0:    begin addr_c_o = ADDR_DAY;      dsel_c_o = SEL_DAY;  end
                    3'd1:    begin addr_c_o = ADDR_MES;      dsel_c_o = SEL_MES;  end
                    3'd2:    begin addr_c_o = ADDR_YEAR;     dsel_c_o = SEL_YEAR; end
                    3'd3:    begin addr_c_o = ADDR_WDAY;     dsel_c_o = SEL_WDAY; end
                    default: begin addr_c_o = CMD_ADDR_TIME; dsel_c_o = SEL_CMD;  end
                endcase
            end
            GRP_TIMER: begin
                last_c_o = (idx_i == IDX_W'(LEN_TIMER - 1));
                case (idx_i)
                    3'd0:    begin addr_c_o = ADDR_SS_T;      dsel_c_o = SEL_SS_T; end
                    3'd1:    begin addr_c_o = ADDR_MM_T;      dsel_c_o = SEL_MM_T; end
                    3'd2:    begin addr_c_o = ADDR_HH_T;      dsel_c_o = SEL_HH_T; end
                    default: begin addr_c_o = CMD_ADDR_TIMER; dsel_c_o = SEL_CMD;  end
                endcase
            end
            default: begin
                addr_c_o = '0;
                dsel_c_o = SEL_CMD;
                last_c_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rtc_config_writer.sv
// Commits edited time/date/timer groups to the RTC as a fixed sequence of bus writes.
// Optional RTC_12H_FORMAT_EN: HH byte carries the PM flag in bit 5.
module rtc_config_writer
    import rtc_cfg_pkg::*;
#(
    parameter logic [ADDR_W-1:0] CMD_ADDR_TIME  = 8'hF1,
    parameter logic [ADDR_W-1:0] CMD_ADDR_TIMER = 8'hF2,
    parameter logic [DATA_W-1:0] CMD_DATA       = 8'hF0,
    parameter int unsigned       TIMEOUT        = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [MODE_W-1:0] config_mode,
    input  logic [DATA_W-1:0] btn_data_SS,
    input  logic [DATA_W-1:0] btn_data_MM,
    input  logic [DATA_W-1:0] btn_data_HH,
    input  logic [DATA_W-1:0] btn_data_YEAR,
    input  logic [DATA_W-1:0] btn_data_MES,
    input  logic [DATA_W-1:0] btn_data_DAY,
    input  logic [DATA_W-1:0] btn_data_SS_T,
    input  logic [DATA_W-1:0] btn_data_MM_T,
    input  logic [DATA_W-1:0] btn_data_HH_T,
    input  logic              AM_PM,
    input  logic [DATA_W-1:0] dia_semana,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ack,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_e              state_q, state_d;
    group_e              grp_q, grp_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MODE_W-1:0]   mode_prev_q;
    snap_t               snap_q, snap_d;
    logic                last_q, last_d;

    logic                wr_req_d, busy_d, done_d, error_d;
    logic [ADDR_W-1:0]   wr_addr_d;
    logic [DATA_W-1:0]   wr_data_d;

    logic                commit_c;
    logic [ADDR_W-1:0]   tbl_addr_c;
    dsel_e               tbl_dsel_c;
    logic                tbl_last_c;
    logic [DATA_W-1:0]   hh_byte_c;
    logic [DATA_W-1:0]   sel_data_c;

    assign commit_c = is_group_mode(mode_prev_q) && (config_mode == MODE_NORMAL);

    // Table is looked up for the write about to be presented next cycle
    rtc_cfg_seq_table #(
        .CMD_ADDR_TIME  (CMD_ADDR_TIME),
        .CMD_ADDR_TIMER (CMD_ADDR_TIMER)
    ) u_seq_table (
        .group_i  (grp_d),
        .idx_i    (idx_d),
        .addr_c_o (tbl_addr_c),
        .dsel_c_o (tbl_dsel_c),
        .last_c_o (tbl_last_c)
    );

`ifdef RTC_12H_FORMAT_EN
    logic unused_hh_bits;
    assign hh_byte_c      = {2'b00, snap_d.am_pm, snap_d.hh[4:0]};
    assign unused_hh_bits = ^snap_d.hh[7:5];
`else
    logic unused_am_pm;
    assign hh_byte_c    = snap_d.hh;
    assign unused_am_pm = snap_d.am_pm;
`endif

    always_comb begin
        sel_data_c = CMD_DATA;
        case (tbl_dsel_c)
            SEL_SS:   sel_data_c = snap_d.ss;
            SEL_MM:   sel_data_c = snap_d.mm;
            SEL_HH:   sel_data_c = hh_byte_c;
            SEL_DAY:  sel_data_c = snap_d.day;
            SEL_MES:  sel_data_c = snap_d.mes;
            SEL_YEAR: sel_data_c = snap_d.year;
            SEL_WDAY: sel_data_c = snap_d.wday;
            SEL_SS_T: sel_data_c = snap_d.ss_t;
            SEL_MM_T: sel_data_c = snap_d.mm_t;
            SEL_HH_T: sel_data_c = snap_d.hh_t;
            default:  sel_data_c = CMD_DATA;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grp_q       <= GRP_TIME;
            idx_q       <= '0;
            cnt_q       <= '0;
            mode_prev_q <= MODE_NORMAL;
            snap_q      <= '0;
            last_q      <= 1'b0;
            wr_req      <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grp_q       <= grp_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            mode_prev_q <= config_mode;
            snap_q      <= snap_d;
            last_q      <= last_d;
            wr_req      <= wr_req_d;
            wr_addr     <= wr_addr_d;
            wr_data     <= wr_data_d;
            busy        <= busy_d;
            done        <= done_d;
            error       <= error_d;
        end
    end

    // Next-state logic; commits outside IDLE are dropped
    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        case (state_q)
            ST_IDLE: begin
                if (commit_c) begin
                    state_d     = ST_ISSUE;
                    grp_d       = mode_to_group(mode_prev_q);
                    idx_d       = '0;
                    cnt_d       = '0;
                    snap_d.ss   = btn_data_SS;
                    snap_d.mm   = btn_data_MM;
                    snap_d.hh   = btn_data_HH;
                    snap_d.year = btn_data_YEAR;
                    snap_d.mes  = btn_data_MES;
                    snap_d.day  = btn_data_DAY;
                    snap_d.wday = dia_semana;
                    snap_d.ss_t = btn_data_SS_T;
                    snap_d.mm_t = btn_data_MM_T;
                    snap_d.hh_t = btn_data_HH_T;
                    snap_d.am_pm = AM_PM;
                end
            end
            ST_ISSUE: begin
                if (wr_ack) begin
                    state_d = ST_GAP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_ABORT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (last_q) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_ISSUE;
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            ST_ABORT:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output logic, registered from the upcoming state so outputs align with it
    always_comb begin
        wr_req_d  = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        last_d    = last_q;
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_FINISH);
        error_d   = (state_d == ST_ABORT);
        if (state_d == ST_ISSUE) begin
            wr_req_d  = 1'b1;
            wr_addr_d = tbl_addr_c;
            wr_data_d = sel_data_c;
            last_d    = tbl_last_c;
        end
    end

endmodule

// File: tb/tb_rtc_config_writer.sv
// Directed and randomized checks of rtc_config_writer against a write-list model.
module tb_rtc_config_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] config_mode;
    logic [7:0] ss, mm, hh, year, mes, day, ss_t, mm_t, hh_t, dia;
    logic       am_pm;
    logic       wr_ack;
    logic       wr_req, busy, done, error;
    logic [7:0] wr_addr, wr_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_addr [5];
    logic [7:0] exp_data [5];
    int         exp_n;

    always #5 clk = ~clk;

    rtc_config_writer dut (
        .clk           (clk),
        .reset         (reset),
        .config_mode   (config_mode),
        .btn_data_SS   (ss),
        .btn_data_MM   (mm),
        .btn_data_HH   (hh),
        .btn_data_YEAR (year),
        .btn_data_MES  (mes),
        .btn_data_DAY  (day),
        .btn_data_SS_T (ss_t),
        .btn_data_MM_T (mm_t),
        .btn_data_HH_T (hh_t),
        .AM_PM         (am_pm),
        .dia_semana    (dia),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ack        (wr_ack),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected write list for a group, from the register map and current input values
    function automatic void model(input int grp);
        logic [7:0] hh_w;
`ifdef RTC_12H_FORMAT_EN
        hh_w = 8'((hh % 32) + (am_pm ? 32 : 0));
`else
        hh_w = hh;
`endif
        exp_n = 0;
        if (grp == 1) begin
            exp_n = 4;
            exp_addr[0] = 8'h21; exp_data[0] = ss;
            exp_addr[1] = 8'h22; exp_data[1] = mm;
            exp_addr[2] = 8'h23; exp_data[2] = hh_w;
            exp_addr[3] = 8'hF1; exp_data[3] = 8'hF0;
        end else if (grp == 2) begin
            exp_n = 5;
            exp_addr[0] = 8'h24; exp_data[0] = day;
            exp_addr[1] = 8'h25; exp_data[1] = mes;
            exp_addr[2] = 8'h26; exp_data[2] = year;
            exp_addr[3] = 8'h27; exp_data[3] = dia;
            exp_addr[4] = 8'hF1; exp_data[4] = 8'hF0;
        end else if (grp == 4) begin
            exp_n = 4;
            exp_addr[0] = 8'h41; exp_data[0] = ss_t;
            exp_addr[1] = 8'h42; exp_data[1] = mm_t;
            exp_addr[2] = 8'h43; exp_data[2] = hh_t;
            exp_addr[3] = 8'hF2; exp_data[3] = 8'hF0;
        end
    endfunction

    task automatic randomize_inputs();
        ss   = 8'($urandom); mm   = 8'($urandom); hh   = 8'($urandom);
        year = 8'($urandom); mes  = 8'($urandom); day  = 8'($urandom);
        ss_t = 8'($urandom); mm_t = 8'($urandom); hh_t = 8'($urandom);
        dia  = 8'($urandom); am_pm = 1'($urandom);
    endtask

    // Leave config mode m; afterwards we sit in the cycle after the commit cycle
    task automatic commit(input logic [2:0] m);
        config_mode = m;
        tick();
        config_mode = 3'd0;
        tick();
    endtask

    // Act as the bus driver: ack each write after lat cycles and check the stream.
    // Returns early, still in ISSUE, when write index stop_at is being presented.
    task automatic serve(input int lat, input bit disturb, input int stop_at, input string tag);
        for (int k = 0; k < exp_n; k++) begin
            check($sformatf("%s_req%0d", tag, k), 32'(wr_req), 32'd1);
            check($sformatf("%s_addr%0d", tag, k), 32'(wr_addr), 32'(exp_addr[k]));
            check($sformatf("%s_data%0d", tag, k), 32'(wr_data), 32'(exp_data[k]));
            check($sformatf("%s_busy%0d", tag, k), 32'(busy), 32'd1);
            if (k == stop_at) return;
            if (disturb && k == 1) begin
                config_mode = 3'd2;
                randomize_inputs();
                tick();
                config_mode = 3'd0;
                tick();
            end
            for (int i = 1; i < lat; i++) begin
                tick();
                check($sformatf("%s_hold_addr%0d", tag, k), 32'({wr_req, wr_addr, wr_data}),
                      32'({1'b1, exp_addr[k], exp_data[k]}));
            end
            wr_ack = 1'b1;
            tick();
            wr_ack = 1'b0;
            check($sformatf("%s_gap%0d", tag, k), 32'({wr_req, busy, done}), 32'b010);
            tick();
            if (k == exp_n - 1)
                check($sformatf("%s_done", tag), 32'({wr_req, busy, done, error}), 32'b0110);
            else
                check($sformatf("%s_next%0d", tag, k), 32'({wr_req, done}), 32'b10);
        end
        tick();
        check($sformatf("%s_idle", tag), 32'({wr_req, busy, done, error}), 32'b0000);
    endtask

    task automatic expect_quiet(input int cycles, input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (wr_req || busy || done || error) seen++;
            tick();
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int cnt;
        int saw_done;
        int grp;
        reset = 1'b1; config_mode = 3'd0; wr_ack = 1'b0;
        ss = '0; mm = '0; hh = '0; year = '0; mes = '0; day = '0;
        ss_t = '0; mm_t = '0; hh_t = '0; dia = '0; am_pm = 1'b0;
        tick();
        tick();
        check("rst_wr_req", 32'(wr_req), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        tick();

        ss = 8'h45; mm = 8'h30; hh = 8'h11;
        model(1); commit(3'd1); serve(2, 1'b0, 99, "time");

        day = 8'h04; mes = 8'h07; year = 8'h16; dia = 8'h03;
        model(2); commit(3'd2); serve(2, 1'b0, 99, "date");

        ss_t = 8'h10; mm_t = 8'h05; hh_t = 8'h01;
        model(4); commit(3'd4); serve(2, 1'b0, 99, "timer");

        // Non-group mode and a stray ack in IDLE do nothing
        commit(3'd3);
        wr_ack = 1'b1; tick(); wr_ack = 1'b0;
        expect_quiet(8, "mode3_quiet");

        hh = 8'h09; am_pm = 1'b1;
        model(1); commit(3'd1); serve(1, 1'b0, 99, "hh12");

        // Inputs and a second commit arriving mid-sequence must not matter
        ss = 8'h58; mm = 8'h59; hh = 8'h12; am_pm = 1'b0;
        model(1); commit(3'd1); serve(3, 1'b1, 99, "snap");
        expect_quiet(8, "busy_commit_dropped");

        // Timeout on the second write
        model(1); commit(3'd1);
        check("to_addr0", 32'(wr_addr), 32'(exp_addr[0]));
        wr_ack = 1'b1; tick(); wr_ack = 1'b0;
        tick();
        check("to_addr1", 32'({wr_req, wr_addr}), 32'({1'b1, exp_addr[1]}));
        cnt = 0; saw_done = 0;
        while (wr_req === 1'b1 && cnt < 300) begin
            if (done) saw_done++;
            cnt++;
            tick();
        end
        check("to_req_cycles", 32'(cnt), 32'd255);
        check("to_error", 32'({wr_req, busy, done, error}), 32'b0101);
        check("to_no_done", 32'(saw_done), 32'd0);
        tick();
        check("to_idle", 32'({wr_req, busy, done, error}), 32'b0000);

        // Reset during the third write
        randomize_inputs();
        model(2); commit(3'd2); serve(2, 1'b0, 2, "rstmid");
        reset = 1'b1;
        tick();
        check("rstmid_outs", 32'({wr_req, busy, done, error, wr_addr, wr_data}), 32'd0);
        reset = 1'b0;
        tick();
        expect_quiet(6, "rstmid_quiet");

        for (int r = 0; r < 8; r++) begin
            randomize_inputs();
            case ($urandom_range(0, 2))
                0:       grp = 1;
                1:       grp = 2;
                default: grp = 4;
            endcase
            model(grp);
            commit(3'(grp));
            serve(int'($urandom_range(1, 4)), 1'(r % 2), 99, $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
